// File: rtl/stream_demux.sv
// stream_demux: steers whole packets from one input stream to one of OUTPUT_NUM
// outputs, each output backed by a single registered slot; bad destinations are dropped.
module stream_demux #(
  parameter int OUTPUT_NUM = 5,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = $clog2(OUTPUT_NUM)
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic [ID_WIDTH-1:0]            dest_i,
  input  logic                           last_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output logic [OUTPUT_NUM*DATA_WIDTH-1:0] data_o,
  output logic [OUTPUT_NUM-1:0]          last_o,
  output logic [OUTPUT_NUM-1:0]          valid_o,
  input  logic [OUTPUT_NUM-1:0]          ready_i,
  output logic [15:0]                    drop_cnt_o
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   cur_dest;
  logic [ID_WIDTH-1:0]   route;
  logic                  route_ok;
  logic                  target_free;
  logic                  accept;
  logic [OUTPUT_NUM-1:0] load;

  // The destination is only looked at on the first beat; later beats follow the lock.
  always_comb begin
    route    = (state == LOCKED) ? cur_dest : dest_i;
    route_ok = (int'(route) < OUTPUT_NUM);
  end

  always_comb begin
    target_free = 1'b1;
    for (int i = 0; i < OUTPUT_NUM; i++) begin
      if (route_ok && (int'(route) == i)) begin
        target_free = !valid_o[i] || ready_i[i];
      end
    end
  end

  // Beats to a nonexistent output are always accepted so a bad packet cannot stall the input.
  assign ready_o = ARESETn && target_free;
  assign accept  = valid_i && ready_o;

  always_comb begin
    load = '0;
    for (int i = 0; i < OUTPUT_NUM; i++) begin
      load[i] = accept && route_ok && (int'(route) == i);
    end
  end

  // A loading slot stays valid even while draining, giving one beat per cycle.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      valid_o <= '0;
      last_o  <= '0;
      data_o  <= '0;
    end else begin
      for (int i = 0; i < OUTPUT_NUM; i++) begin
        if (load[i]) begin
          data_o[i*DATA_WIDTH +: DATA_WIDTH] <= data_i;
          last_o[i]                          <= last_i;
          valid_o[i]                         <= 1'b1;
        end else if (ready_i[i]) begin
          valid_o[i] <= 1'b0;
        end
      end
    end
  end

  // Packet framing is tracked the same way whether or not the packet is being dropped.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      cur_dest   <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (accept) begin
        case (state)
          IDLE: begin
            if (!last_i) begin
              state    <= LOCKED;
              cur_dest <= dest_i;
            end
          end
          LOCKED: begin
            if (last_i) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
        if (!route_ok && (drop_cnt_o != 16'hFFFF)) begin
          drop_cnt_o <= drop_cnt_o + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed checks of routing, locking, backpressure, drops and reset,
// followed by a short random run against a per-output scoreboard.
module tb_stream_demux;

  localparam int N  = 5;
  localparam int DW = 16;
  localparam int IW = 3;

  logic            ACLK = 1'b0;
  logic            ARESETn;
  logic [DW-1:0]   data_i;
  logic [IW-1:0]   dest_i;
  logic            last_i;
  logic            valid_i;
  logic            ready_o;
  logic [N*DW-1:0] data_o;
  logic [N-1:0]    last_o;
  logic [N-1:0]    valid_o;
  logic [N-1:0]    ready_i;
  logic [15:0]     drop_cnt_o;

  int checks = 0;
  int fails  = 0;

  stream_demux #(.OUTPUT_NUM(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .data_i(data_i), .dest_i(dest_i),
    .last_i(last_i), .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o),
    .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i), .drop_cnt_o(drop_cnt_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [IW-1:0] d, input logic l, input logic [DW-1:0] x);
    valid_i = v;
    dest_i  = d;
    last_i  = l;
    data_i  = x;
  endtask

  function automatic logic [DW-1:0] slot(input int i);
    return data_o[i*DW +: DW];
  endfunction

  logic [DW:0]   sb [N][$];
  logic [N-1:0]  prev_valid;
  logic [N-1:0]  prev_ready;
  logic [DW-1:0] prev_data [N];
  logic [IW-1:0] lock_dest;
  logic [IW-1:0] mroute;
  logic          in_pkt;
  logic          rvalid;
  logic          exp_ready;
  logic [DW:0]   exp_beat;
  int            exp_drop;
  logic [IW-1:0] pkt_dest [3];

  initial begin
    ARESETn = 1'b0;
    ready_i = '1;
    applyStimulus(1'b0, '0, 1'b0, '0);

    // reset state
    @(negedge ACLK);
    #1;
    checkOutput("rst_ready", ready_o, 0);
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_last", last_o, 0);
    checkOutput("rst_data", slot(2), 0);
    checkOutput("rst_drop", drop_cnt_o, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    checkOutput("rel_ready", ready_o, 1);

    // single beat to output 2
    @(negedge ACLK);
    applyStimulus(1'b1, 3'd2, 1'b1, 16'hCCCC);
    #1 checkOutput("single_ready", ready_o, 1);
    @(negedge ACLK);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("single_valid", valid_o, 5'b00100);
    checkOutput("single_data", slot(2), 16'hCCCC);
    checkOutput("single_last", last_o[2], 1);
    @(negedge ACLK);
    checkOutput("single_drain", valid_o, 0);

    // packet lock: later dest_i changes must be ignored
    pkt_dest[0] = 3'd1;
    pkt_dest[1] = 3'd4;
    pkt_dest[2] = 3'd4;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, pkt_dest[k], (k == 2), 16'(k + 1));
      #1 checkOutput("lock_ready", ready_o, 1);
      @(negedge ACLK);
      checkOutput("lock_valid", valid_o, 5'b00010);
      checkOutput("lock_data", slot(1), 32'(k + 1));
      checkOutput("lock_last", last_o[1], (k == 2));
    end
    applyStimulus(1'b1, 3'd0, 1'b1, 16'hAAAA);
    @(negedge ACLK);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("unlock_valid", valid_o, 5'b00001);
    checkOutput("unlock_data", slot(0), 16'hAAAA);
    @(negedge ACLK);

    // backpressure on output 0
    ready_i = 5'b11110;
    applyStimulus(1'b1, 3'd0, 1'b1, 16'h00A1);
    #1 checkOutput("bp_ready_first", ready_o, 1);
    @(negedge ACLK);
    checkOutput("bp_valid_first", valid_o, 5'b00001);
    checkOutput("bp_data_first", slot(0), 16'h00A1);
    applyStimulus(1'b1, 3'd0, 1'b1, 16'h00B2);
    #1 checkOutput("bp_ready_blocked", ready_o, 0);
    @(negedge ACLK);
    checkOutput("bp_hold_valid", valid_o, 5'b00001);
    checkOutput("bp_hold_data", slot(0), 16'h00A1);
    ready_i = 5'b11111;
    #1 checkOutput("bp_ready_release", ready_o, 1);
    @(negedge ACLK);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("bp_valid_second", valid_o, 5'b00001);
    checkOutput("bp_data_second", slot(0), 16'h00B2);
    @(negedge ACLK);
    checkOutput("bp_no_dup", valid_o, 0);

    // invalid destination, 4-beat packet
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, (k == 0) ? 3'd7 : 3'd0, (k == 3), 16'hD000 + 16'(k));
      #1 checkOutput("drop_ready", ready_o, 1);
      @(negedge ACLK);
      checkOutput("drop_no_valid", valid_o, 0);
    end
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("drop_count", drop_cnt_o, 4);

    // reset in the middle of a packet to output 3
    applyStimulus(1'b1, 3'd3, 1'b0, 16'h0031);
    @(negedge ACLK);
    checkOutput("mid_valid1", valid_o, 5'b01000);
    applyStimulus(1'b1, 3'd3, 1'b0, 16'h0032);
    @(negedge ACLK);
    checkOutput("mid_data2", slot(3), 16'h0032);
    ARESETn = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    #1;
    checkOutput("mid_rst_valid", valid_o, 0);
    checkOutput("mid_rst_drop", drop_cnt_o, 0);
    checkOutput("mid_rst_ready", ready_o, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    applyStimulus(1'b1, 3'd0, 1'b1, 16'h0E0E);
    @(negedge ACLK);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("post_rst_valid", valid_o, 5'b00001);
    checkOutput("post_rst_data", slot(0), 16'h0E0E);
    checkOutput("post_rst_slot3", slot(3), 0);
    repeat (2) @(negedge ACLK);

    // random soak against a packet-level model
    in_pkt    = 1'b0;
    lock_dest = '0;
    exp_drop  = 0;
    prev_valid = '0;
    prev_ready = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge ACLK);
      applyStimulus($urandom_range(0, 3) != 0, IW'($urandom_range(0, 5)),
                    $urandom_range(0, 2) == 0, DW'($urandom));
      ready_i = N'($urandom) | N'($urandom);
      #1;
      for (int i = 0; i < N; i++) begin
        if (prev_valid[i] && !prev_ready[i]) begin
          checkOutput("soak_hold", valid_o[i], 1);
          checkOutput("soak_stable", slot(i), prev_data[i]);
        end
        checkOutput("soak_occupancy", valid_o[i], sb[i].size() != 0);
        if (valid_o[i] && ready_i[i] && sb[i].size() != 0) begin
          exp_beat = sb[i].pop_front();
          checkOutput("soak_beat", {last_o[i], slot(i)}, exp_beat);
        end
      end
      mroute = in_pkt ? lock_dest : dest_i;
      rvalid = (int'(mroute) < N);
      exp_ready = 1'b1;
      if (rvalid) exp_ready = !valid_o[mroute] || ready_i[mroute];
      checkOutput("soak_ready", ready_o, exp_ready);
      if (valid_i && exp_ready) begin
        if (rvalid) sb[mroute].push_back({last_i, data_i});
        else exp_drop++;
        if (!in_pkt && !last_i) begin
          in_pkt    = 1'b1;
          lock_dest = dest_i;
        end else if (in_pkt && last_i) begin
          in_pkt = 1'b0;
        end
      end
      prev_valid = valid_o;
      prev_ready = ready_i;
      for (int i = 0; i < N; i++) prev_data[i] = slot(i);
    end
    @(negedge ACLK);
    applyStimulus(1'b0, '0, 1'b0, '0);
    ready_i = '1;
    @(negedge ACLK);
    checkOutput("soak_drop", drop_cnt_o, 32'(exp_drop));
    checkOutput("soak_drained", valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
